mux4to1: RTL and testbench



---
 rtl/mux4to1.sv | 100 ++++++++++
 tb/tb_mux4to1.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/mux4to1.sv
// Registered 4:1 word multiplexer with a STAGES-deep valid-tagged pipeline ending in C/c_valid.
// Optional MUX4TO1_PARITY_EN adds c_parity, the XOR of the word delivered with c_valid.
module mux4to1 #(
    parameter int WIDTH  = 4,
    parameter int STAGES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       sel,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] D,
    input  logic [WIDTH-1:0] E,
`ifdef MUX4TO1_PARITY_EN
    output logic             c_parity,
`endif
    output logic [WIDTH-1:0] C,
    output logic             c_valid
);

    // Handshake: a word is accepted on every rising clk where en=1 and rst=0; it is
    // delivered exactly once, in order, as a one-cycle c_valid pulse. There is no back-pressure.

    generate
        if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
            $error("mux4to1: STAGES must be in 1..4");
        end
    endgenerate

    logic [WIDTH-1:0] sel_word;
    logic [WIDTH-1:0] last_d;
    logic             last_v;

    always_comb begin
        sel_word = A;
        case (sel)
            2'b00:   sel_word = A;
            2'b01:   sel_word = B;
            2'b10:   sel_word = D;
            default: sel_word = E;
        endcase
    end

    // The output register is the final stage, so only STAGES-1 stages sit in front of it.
    generate
        if (STAGES == 1) begin : g_direct
            assign last_d = sel_word;
            assign last_v = en;
        end else begin : g_pipe
            logic [WIDTH-1:0] pipe_d [STAGES-1];
            logic [STAGES-2:0] pipe_v;

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int k = 0; k < STAGES - 1; k++) begin
                        pipe_d[k] <= '0;
                    end
                    pipe_v <= '0;
                end else begin
                    pipe_v[0] <= en;
                    if (en) begin
                        pipe_d[0] <= sel_word;
                    end
                    for (int k = 1; k < STAGES - 1; k++) begin
                        pipe_d[k] <= pipe_d[k-1];
                        pipe_v[k] <= pipe_v[k-1];
                    end
                end
            end

            assign last_d = pipe_d[STAGES-2];
            assign last_v = pipe_v[STAGES-2];
        end
    endgenerate

    // C holds between deliveries so it always shows the most recent delivered word.
    always_ff @(posedge clk) begin
        if (rst) begin
            C       <= '0;
            c_valid <= 1'b0;
        end else begin
            c_valid <= last_v;
            if (last_v) begin
                C <= last_d;
            end
        end
    end

`ifdef MUX4TO1_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            c_parity <= 1'b0;
        end else if (last_v) begin
            c_parity <= ^last_d;
        end
    end
`endif

endmodule

// File: tb/tb_mux4to1.sv
// Bench for mux4to1: STAGES=1 and STAGES=3 instances share stimulus and are compared every
// cycle against a capture-history model, plus directed literal checks.
module tb_mux4to1;
  localparam int W = 4;
  localparam int HMAX = 4096;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0;
  logic [1:0]   sel = 2'b00;
  logic [W-1:0] a = '0, b = '0, d = '0, e = '0;

  logic [W-1:0] c1, c3;
  logic         cv1, cv3;
`ifdef MUX4TO1_PARITY_EN
  logic         cp1, cp3;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mux4to1 #(.WIDTH(W), .STAGES(1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .sel(sel),
    .A(a), .B(b), .D(d), .E(e),
`ifdef MUX4TO1_PARITY_EN
    .c_parity(cp1),
`endif
    .C(c1), .c_valid(cv1)
  );

  mux4to1 #(.WIDTH(W), .STAGES(3)) dut3 (
    .clk(clk), .rst(rst), .en(en), .sel(sel),
    .A(a), .B(b), .D(d), .E(e),
`ifdef MUX4TO1_PARITY_EN
    .c_parity(cp3),
`endif
    .C(c3), .c_valid(cv3)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // ---------------- model: history of edges, what was captured and when reset hit ----------------
  logic         hist_rst [HMAX];
  logic         hist_cap [HMAX];
  logic [W-1:0] hist_w   [HMAX];
  int           t = 0;
  logic [W-1:0] exp_c1 = '0, exp_c3 = '0;
  logic         exp_v1 = 1'b0, exp_v3 = 1'b0;

  // A word captured at edge idx is delivered at edge idx+s-1 unless reset occurred in between.
  function automatic bit delivered(int edge_i, int s);
    int idx;
    idx = edge_i - s + 1;
    if (idx < 0) return 1'b0;
    if (!hist_cap[idx]) return 1'b0;
    for (int j = idx; j <= edge_i; j++) begin
      if (hist_rst[j]) return 1'b0;
    end
    return 1'b1;
  endfunction

  always @(posedge clk) begin : model_and_compare
    logic [W-1:0] words [4];
    int now;
    words = '{a, b, d, e};
    now = t;
    hist_rst[now] = rst;
    hist_cap[now] = en && !rst;
    hist_w[now]   = words[sel];
    t = t + 1;

    exp_v1 = delivered(now, 1);
    exp_v3 = delivered(now, 3);
    if (rst) exp_c1 = '0;
    else if (exp_v1) exp_c1 = hist_w[now];
    if (rst) exp_c3 = '0;
    else if (exp_v3) exp_c3 = hist_w[now - 2];

    #2;
    check("m_c_s1", c1, exp_c1);
    check("m_valid_s1", cv1, exp_v1);
    check("m_c_s3", c3, exp_c3);
    check("m_valid_s3", cv3, exp_v3);
`ifdef MUX4TO1_PARITY_EN
    check("m_par_s1", cp1, ^exp_c1);
    check("m_par_s3", cp3, ^exp_c3);
`endif
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic r, input logic v, input logic [1:0] s,
                       input logic [W-1:0] va, input logic [W-1:0] vb,
                       input logic [W-1:0] vd, input logic [W-1:0] ve);
    @(negedge clk);
    rst = r; en = v; sel = s; a = va; b = vb; d = vd; e = ve;
  endtask

  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  task automatic cycle(input logic r, input logic v, input logic [1:0] s,
                       input logic [W-1:0] va, input logic [W-1:0] vb,
                       input logic [W-1:0] vd, input logic [W-1:0] ve);
    drive(r, v, s, va, vb, vd, ve);
    tick();
  endtask

  task automatic flush();
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 2'b00, '0, '0, '0, '0);
  endtask

  logic [W-1:0] sweep_exp [4];

  initial begin
    sweep_exp = '{4'b0011, 4'b1100, 4'b0101, 4'b1010};

    // Reset held two cycles with a capture request pending.
    for (int i = 0; i < 2; i++) begin
      cycle(1'b1, 1'b1, 2'b01, 4'b0000, 4'b1111, 4'b0000, 4'b0000);
      check("rst_c", c1, 4'b0000);
      check("rst_valid", cv1, 1'b0);
      check("rst_c_s3", c3, 4'b0000);
    end

    // Select sweep; the first edge after rst falls is the first capture.
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b1, 2'(i), 4'b0011, 4'b1100, 4'b0101, 4'b1010);
      check("sweep_c", c1, sweep_exp[i]);
      check("sweep_valid", cv1, 1'b1);
    end

    // Hold: inputs change while en=0.
    cycle(1'b0, 1'b1, 2'b01, 4'b0000, 4'b0110, 4'b0000, 4'b0000);
    check("hold_cap_c", c1, 4'b0110);
    check("hold_cap_valid", cv1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, 2'(i + 2), 4'b1111, 4'b1001, 4'b1110, 4'b1101);
      check("hold_c", c1, 4'b0110);
      check("hold_valid", cv1, 1'b0);
    end

    // Latency with STAGES=3: single pulse at edge N shows only at N+2.
    flush();
    cycle(1'b0, 1'b1, 2'b00, 4'b0111, 4'b0000, 4'b0000, 4'b0000);
    check("lat_n_valid", cv3, 1'b0);
    cycle(1'b0, 1'b0, 2'b00, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    check("lat_n1_valid", cv3, 1'b0);
    cycle(1'b0, 1'b0, 2'b00, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    check("lat_n2_valid", cv3, 1'b1);
    check("lat_n2_c", c3, 4'b0111);
    cycle(1'b0, 1'b0, 2'b00, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    check("lat_n3_valid", cv3, 1'b0);
    check("lat_n3_c", c3, 4'b0111);

    // Reset mid-flight: word captured at N is discarded by rst at N+1.
    cycle(1'b0, 1'b1, 2'b10, 4'b0000, 4'b0000, 4'b0101, 4'b0000);
    cycle(1'b1, 1'b0, 2'b00, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    check("mid_rst_c", c3, 4'b0000);
    check("mid_rst_valid", cv3, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, 2'b00, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
      check("mid_rst_after_valid", cv3, 1'b0);
      check("mid_rst_after_c", c3, 4'b0000);
    end

`ifdef MUX4TO1_PARITY_EN
    cycle(1'b0, 1'b1, 2'b00, 4'b0111, 4'b0000, 4'b0000, 4'b0000);
    check("parity_odd", cp1, 1'b1);
    cycle(1'b0, 1'b1, 2'b01, 4'b0000, 4'b0011, 4'b0000, 4'b0000);
    check("parity_even", cp1, 1'b0);
`endif

    // en toggling every cycle with random data.
    for (int i = 0; i < 24; i++) begin
      cycle(1'b0, 1'(i % 2), 2'($urandom_range(0, 3)), 4'($urandom), 4'($urandom),
            4'($urandom), 4'($urandom));
    end

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 39) == 0), ($urandom_range(0, 9) < 6),
            2'($urandom_range(0, 3)), 4'($urandom), 4'($urandom),
            4'($urandom), 4'($urandom));
    end

    flush();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
